// File: rtl/conv_encoder.sv
// -----------------------------------------------------------------------------
// conv_encoder
//   Rate 1/r, constraint length K, non-terminated convolutional encoder.
//   A frame of lenout message bits (MSB first) is encoded one bit per cycle
//   into an lenin-bit code word. The first symbol lands in the top bits of
//   codeout. A constant expected-parity table is exported for a downstream
//   decoder.
//
//   Optional feature (macro CONV_ENCODER_SYMSTREAM_EN):
//     defined   -> sym/sym_valid stream each symbol as it is written to codeout
//     undefined -> sym and sym_valid are tied to 0
//
// Ports
//   clk        in   clock, all state updates on posedge
//   rst        in   asynchronous active-high reset
//   start      in   encode request, sampled only in IDLE
//   msg        in   [lenout-1:0] message, msg[lenout-1] encoded first
//   busy       out  high while encoding
//   done       out  one-cycle pulse, codeout complete
//   codeout    out  [lenin-1:0] code word
//   states     out  [2^(K-1)*2*r-1:0] parity table, entry n = s*2+u
//   sym_valid  out  per-symbol strobe
//   sym        out  [r-1:0] current symbol
// -----------------------------------------------------------------------------
module conv_encoder #(
  parameter int             r      = 2,
  parameter int             K      = 3,
  parameter int             lenout = 5,
  parameter int             lenin  = 10,
  parameter logic [K-1:0]   G0     = 3'b111,
  parameter logic [K-1:0]   G1     = 3'b101
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [lenout-1:0]                 msg,
  output logic                              busy,
  output logic                              done,
  output logic [lenin-1:0]                  codeout,
  output logic [(1<<(K-1))*2*r-1:0]         states,
  output logic                              sym_valid,
  output logic [r-1:0]                      sym
);

  localparam int NSTATE = 1 << (K-1);
  localparam int SW     = NSTATE * 2 * r;
  localparam int CNT_W  = $clog2(lenout + 1);

  typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;

  // Symbol for encoder register {u, s}: MSB from G0, LSB from G1.
  function automatic logic [r-1:0] enc_sym(input logic [K-1:0] regv);
    logic [r-1:0] res;
    res      = '0;
    res[r-1] = ^(G0 & regv);
    res[0]   = ^(G1 & regv);
    return res;
  endfunction

  // Entry n = s*2+u, so u is n[0] and s is n[K-1:1]; the register is {u, s}.
  function automatic logic [SW-1:0] build_table();
    logic [SW-1:0] t;
    logic [K-1:0]  n_v;
    t = '0;
    for (int n = 0; n < 2 * NSTATE; n++) begin
      n_v = K'(n);
      t   = t | (SW'(enc_sym({n_v[0], n_v[K-1:1]})) << (n * r));
    end
    return t;
  endfunction

  localparam logic [SW-1:0] STATES_TBL = build_table();

  state_t            state_q, state_d;
  logic [K-2:0]      s_q, s_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [lenin-1:0]  codeout_q, codeout_d;
  logic [lenout-1:0] msg_q, msg_d;

  // The captured message shifts left each ENC cycle, so the bit being
  // encoded is always its MSB.
  logic              u;
  logic [K-1:0]      enc_reg;
  logic [r-1:0]      enc_out;

  assign u       = msg_q[lenout-1];
  assign enc_reg = {u, s_q};
  assign enc_out = enc_sym(enc_reg);

`ifdef CONV_ENCODER_SYMSTREAM_EN
  logic              sym_valid_q, sym_valid_d;
  logic [r-1:0]      sym_q, sym_d;
`endif

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    cnt_d     = cnt_q;
    codeout_d = codeout_q;
    msg_d     = msg_q;
`ifdef CONV_ENCODER_SYMSTREAM_EN
    sym_d       = '0;
    sym_valid_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ENC;
          msg_d     = msg;
          s_d       = '0;
          cnt_d     = '0;
          codeout_d = '0;
        end
      end
      ENC: begin
        // codeout was cleared on start, so OR-ing places symbol i at
        // codeout[lenin-1-r*i -: r] without disturbing earlier symbols.
        codeout_d = codeout_q
                  | (lenin'(enc_out) << (lenin - r * (int'(cnt_q) + 1)));
        s_d       = enc_reg[K-1:1];
        msg_d     = msg_q << 1;
        cnt_d     = cnt_q + CNT_W'(1);
`ifdef CONV_ENCODER_SYMSTREAM_EN
        sym_d       = enc_out;
        sym_valid_d = 1'b1;
`endif
        if (cnt_q == CNT_W'(lenout - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      s_q       <= '0;
      cnt_q     <= '0;
      codeout_q <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      codeout_q <= codeout_d;
    end
  end

  // Message capture needs no reset: it is only read in ENC, after a start
  // has loaded it.
  always_ff @(posedge clk) begin
    msg_q <= msg_d;
  end

`ifdef CONV_ENCODER_SYMSTREAM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
    end else begin
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
    end
  end

  assign sym       = sym_q;
  assign sym_valid = sym_valid_q;
`else
  assign sym       = '0;
  assign sym_valid = 1'b0;
`endif

  assign busy    = (state_q == ENC);
  assign done    = (state_q == DONE);
  assign codeout = codeout_q;
  assign states  = STATES_TBL;

endmodule

// File: tb/tb_conv_encoder.sv
// -----------------------------------------------------------------------------
// tb_conv_encoder
//   Directed bench for conv_encoder with default parameters. Expected code
//   words and symbol sequences are hand-computed for generators 111/101.
// -----------------------------------------------------------------------------
module tb_conv_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  msg;
  logic        busy;
  logic        done;
  logic [9:0]  codeout;
  logic [15:0] states;
  logic        sym_valid;
  logic [1:0]  sym;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  conv_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .msg       (msg),
    .busy      (busy),
    .done      (done),
    .codeout   (codeout),
    .states    (states),
    .sym_valid (sym_valid),
    .sym       (sym)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until done is seen, or -1 if it never is.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_frame(input logic [4:0] m, input logic [9:0] exp,
                           input string tag);
    int n;
    msg   = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    check({tag, "_latency"}, n, 5);
    check({tag, "_code"}, codeout, exp);
    tick();
  endtask

  logic [9:0] part_exp [5];
  logic [1:0] sym_exp  [5];
  int         n;
  logic       saw_done;

  initial begin
    part_exp = '{10'b1100000000, 10'b1110000000, 10'b1110000000,
                 10'b1110000100, 10'b1110000101};
    sym_exp  = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01};

    rst   = 1'b1;
    start = 1'b0;
    msg   = '0;
    #3;
    check("rst_states",    states,    16'h963C);
    check("rst_codeout",   codeout,   10'd0);
    check("rst_busy",      busy,      1'b0);
    check("rst_done",      done,      1'b0);
    check("rst_sym_valid", sym_valid, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 1'b0);

    // Frame 1: step-by-step, msg changed right after capture.
    msg   = 5'b10110;
    start = 1'b1;
    tick();
    start = 1'b0;
    msg   = 5'b01111;
    check("f1_busy_e0", busy, 1'b1);
    check("f1_done_e0", done, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("f1_code_e%0d", k + 1), codeout, part_exp[k]);
      check($sformatf("f1_busy_e%0d", k + 1), busy, (k < 4) ? 1'b1 : 1'b0);
      check($sformatf("f1_done_e%0d", k + 1), done, (k < 4) ? 1'b0 : 1'b1);
`ifdef CONV_ENCODER_SYMSTREAM_EN
      check($sformatf("f1_symv_e%0d", k + 1), sym_valid, 1'b1);
      check($sformatf("f1_sym_e%0d", k + 1),  sym,       sym_exp[k]);
`else
      check($sformatf("f1_symv_e%0d", k + 1), sym_valid, 1'b0);
      check($sformatf("f1_sym_e%0d", k + 1),  sym,       2'b00);
`endif
    end
    tick();
    check("f1_done_drop", done,      1'b0);
    check("f1_busy_idle", busy,      1'b0);
    check("f1_symv_end",  sym_valid, 1'b0);
    check("f1_code_hold", codeout,   10'b1110000101);
    tick();
    msg = 5'b00000;
    tick();
    check("f1_code_hold2", codeout, 10'b1110000101);

    run_frame(5'b10000, 10'b1110110000, "f2");
    run_frame(5'b00000, 10'b0000000000, "f3");

    // start held high; msg changes during ENC; next frame waits for IDLE.
    msg   = 5'b10110;
    start = 1'b1;
    tick();
    msg = 5'b01001;
    wait_done(n);
    check("f4_latency", n, 5);
    check("f4_code", codeout, 10'b1110000101);
    tick();
    check("f4_idle_busy", busy, 1'b0);
    check("f4_idle_done", done, 1'b0);
    tick();
    check("f5_busy", busy, 1'b1);
    start = 1'b0;
    wait_done(n);
    check("f5_latency", n, 5);
    check("f5_code", codeout, 10'b0011101111);
    tick();

    // Reset in the third ENC cycle aborts the frame.
    msg   = 5'b10110;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("abort_busy_pre", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy",    busy,      1'b0);
    check("abort_done",    done,      1'b0);
    check("abort_codeout", codeout,   10'd0);
    check("abort_symv",    sym_valid, 1'b0);
    check("abort_sym",     sym,       2'b00);
    tick();
    rst      = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      saw_done = saw_done | done;
    end
    check("abort_no_done", saw_done, 1'b0);
    check("abort_idle",    busy,     1'b0);
    run_frame(5'b10110, 10'b1110000101, "f6");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 Parameter r, default 2: parity bits per message bit.
REQ-002 Parameter K, default 3: constraint length.
REQ-003 Parameter lenout, default 5: message length in bits.
REQ-004 Parameter lenin, default 10: code word length; SHALL equal lenout*r.
REQ-005 Parameter G0, default 3'b111: generator for parity bit 1 of each symbol (symbol MSB).
REQ-006 Parameter G1, default 3'b101: generator for parity bit 0 of each symbol (symbol LSB).
REQ-007 clk  in  1  single clock; all state updates on posedge.
REQ-008 rst  in  1  reset; asynchronous and active-high.
REQ-009 start  in  1  encode request; sampled only in IDLE.
REQ-010 msg  in  lenout  message; msg[lenout-1] is encoded first.
REQ-011 busy  out  1  high while in ENC.
REQ-012 done  out  1  one-cycle pulse; codeout complete.
REQ-013 codeout  out  lenin  code word; first symbol in codeout[lenin-1:lenin-2].
REQ-014 states  out  2^(K-1)*2*r  expected-parity table for the downstream decoder.
REQ-015 sym_valid  out  1  per-symbol strobe (see Configuration).
REQ-016 sym  out  r  current symbol (see Configuration).

Function
REQ-017 The encoder shift state s SHALL be K-1 bits wide, with s[K-2] holding the most recent input bit; the encoder register SHALL be {u, s}.
REQ-018 Symbol bit 1 SHALL be the XOR-reduce of (G0 & {u,s}); symbol bit 0 SHALL be the XOR-reduce of (G1 & {u,s}); the next state SHALL be {u, s[K-2:1]}.
REQ-019 states entry index n = s*2+u SHALL occupy bits [n*r+r-1 : n*r] and SHALL equal the symbol from REQ-018; the table SHALL be constant, derived from G0/G1, and independent of reset.
REQ-020 The FSM SHALL have three states: IDLE, ENC, DONE. IDLE->ENC when start=1; ENC->DONE after the lenout-th symbol; DONE->IDLE unconditionally after one cycle.
REQ-021 On accepting start, the block SHALL capture msg, clear s to 0, clear the bit counter, and clear codeout to 0.
REQ-022 Each ENC cycle SHALL encode exactly one bit: bit i (i=0..lenout-1, taken from msg[lenout-1-i]) SHALL be written to codeout[lenin-1-r*i -: r].
REQ-023 Latency: start sampled at edge E0; symbols SHALL be registered at edges E1..E5; done SHALL be high for the cycle after E5 (with default parameters).
REQ-024 start SHALL be ignored in ENC and DONE; changes to msg after capture SHALL have no effect.
REQ-025 codeout SHALL hold its value from done until the next accepted start.
REQ-026 No tail (flush) bits SHALL be appended; the trellis is not terminated.
REQ-027 busy SHALL be 1 exactly in ENC; done SHALL be 1 exactly in DONE.

Reset
REQ-028 While rst=1: FSM=IDLE, s=0, counter=0, codeout=0, busy=0, done=0, sym_valid=0, sym=0, immediately and regardless of clk.
REQ-029 Reset asserted mid-ENC SHALL abort the frame; no done SHALL follow; the first start after release SHALL begin a fresh frame.

Configuration
REQ-030 With macro CONV_ENCODER_SYMSTREAM_EN defined, sym SHALL carry each newly encoded symbol and sym_valid SHALL pulse high for the same cycle as that symbol becomes visible in codeout (5 pulses per frame with default parameters).
REQ-031 Without CONV_ENCODER_SYMSTREAM_EN, sym and sym_valid SHALL be tied to 0; codeout, done and busy behaviour SHALL be unchanged.

Verification
REQ-032 After reset, with defaults: states SHALL equal 16'h963C, and codeout=0, done=0, busy=0.
REQ-033 msg=5'b10110 with a one-cycle start -> busy for 5 cycles, then done pulses, and codeout SHALL be 10'b1110000101.
REQ-034 msg=5'b10000 -> codeout SHALL be 10'b1110110000; msg=5'b00000 -> codeout SHALL be 10'b0000000000.
REQ-035 start held high continuously with msg changing during ENC -> result SHALL match the captured msg, and the next frame SHALL start only after DONE->IDLE.
REQ-036 rst pulsed at the 3rd ENC cycle -> all outputs SHALL be 0, with no done; a new start with 5'b10110 -> codeout SHALL be 10'b1110000101.
REQ-037 With CONV_ENCODER_SYMSTREAM_EN defined and msg=5'b10110 -> sym sequence SHALL be 11,10,00,01,01 with 5 sym_valid pulses; with the macro undefined -> sym_valid SHALL stay 0.
